// File: rtl/reader_pkg.sv
// rtl/reader_pkg.sv - shared types and defaults for the memory result reader
package reader_pkg;

  localparam int WORD_W = 16;

  localparam int DEF_BASE_ADDR = 1000;
  localparam int DEF_NUM_WORDS = 10;
  localparam int DEF_STRIDE    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_SEND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_result_reader.sv
// rtl/mem_result_reader.sv - sweeps result words out of data memory onto a valid/ready port (optional READER_CHECKSUM_EN running sum)
module mem_result_reader
  import reader_pkg::*;
#(
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int STRIDE    = DEF_STRIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [WORD_W-1:0] addr,
  output logic              en,
  input  logic [WORD_W-1:0] rd_data,
  output logic [WORD_W-1:0] out_data,
  output logic [WORD_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [WORD_W-1:0] BASE16   = WORD_W'(BASE_ADDR);
  localparam logic [WORD_W-1:0] STRIDE16 = WORD_W'(STRIDE);
  localparam logic [WORD_W-1:0] LAST_IDX = WORD_W'(NUM_WORDS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WORD_W-1:0] idx_q;
  logic              last_word;
  logic              capture;

  assign last_word = (idx_q == LAST_IDX);
  assign capture   = (state_q == ST_READ) && bus_gnt;

  // The bus is released outside a sweep, so the address collapses to zero then.
  assign addr = bus_req ? WORD_W'(BASE16 + idx_q * STRIDE16) : '0;
  assign en   = 1'b0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_gnt) state_d = ST_READ;
      end
      ST_READ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_gnt) state_d = ST_SEND;
      end
      ST_SEND: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = last_word ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word index and the captured output word; data is frozen for the whole SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
        idx_q <= '0;
      end
      if (capture) begin
        out_data <= rd_data;
        out_idx  <= idx_q;
      end
      if (state_q == ST_SEND && out_ready && !last_word) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef READER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;

  // Running wrap-around sum of every captured word, cleared when a sweep starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
      sum_q <= '0;
    end else if (capture) begin
      sum_q <= sum_q + rd_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_result_reader.sv
// tb/tb_mem_result_reader.sv - self-checking bench for mem_result_reader
module tb_mem_result_reader;

`ifdef READER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, bus_gnt, out_ready;
  logic        bus_req, en, out_valid, busy, done;
  logic [15:0] addr, rd_data, out_data, out_idx, checksum, addr_p1;

  logic        start_b, bus_gnt_b, out_ready_b;
  logic        bus_req_b, en_b, out_valid_b, busy_b, done_b;
  logic [15:0] addr_b, rd_data_b, out_data_b, out_idx_b, checksum_b, addr_b_p1;

  logic [7:0] mem [0:65535];

  assign addr_p1   = addr + 16'd1;
  assign addr_b_p1 = addr_b + 16'd1;
  assign rd_data   = {mem[addr_p1], mem[addr]};
  assign rd_data_b = {mem[addr_b_p1], mem[addr_b]};

  mem_result_reader dut (
    .clk(clk), .rst(rst), .start(start), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .addr(addr), .en(en), .rd_data(rd_data), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .checksum(checksum)
  );

  mem_result_reader #(.BASE_ADDR(16'hFFFE), .NUM_WORDS(2), .STRIDE(2)) dut_wrap (
    .clk(clk), .rst(rst), .start(start_b), .bus_req(bus_req_b), .bus_gnt(bus_gnt_b),
    .addr(addr_b), .en(en_b), .rd_data(rd_data_b), .out_data(out_data_b), .out_idx(out_idx_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b), .done(done_b),
    .checksum(checksum_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cnt = 0;

  always @(posedge clk) cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a sweep is the list of words at BASE + k*STRIDE, delivered in order.
  logic [15:0] q_idx[$];
  logic [15:0] q_data[$];
  bit          m_active, m_done;
  logic [15:0] m_sum;
  bit          pv, phs;
  logic [15:0] pd, pi;

  // Compare DUT outputs against the model once per cycle, away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      q_idx.delete();
      q_data.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_sum    = '0;
      pv       = 1'b0;
      phs      = 1'b0;
    end else begin
      chk("en_low", en, 0);
      chk("busy", busy, m_active);
      chk("bus_req", bus_req, m_active);
      chk("done", done, m_done);
      if (m_done) chk("checksum", checksum, CK_EN ? m_sum : 16'h0000);
      if (bus_req) begin
        if (q_idx.size() == 0) chk("addr_no_word_pending", 0, 1);
        else chk("addr_word", addr, 16'(16'd1000 + q_idx[0] * 16'd2));
      end else begin
        chk("addr_released", addr, 0);
      end
      if (pv && !phs) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_idx", out_idx, pi);
      end
      phs = out_valid && out_ready;
      pv  = out_valid;
      pd  = out_data;
      pi  = out_idx;
      if (phs) begin
        if (q_idx.size() == 0) begin
          chk("unexpected_word", 0, 1);
        end else begin
          chk("word_data", out_data, q_data[0]);
          chk("word_idx", out_idx, q_idx[0]);
          void'(q_idx.pop_front());
          void'(q_data.pop_front());
          if (q_idx.size() == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end
      if (start && !m_active) begin
        m_active = 1'b1;
        m_done   = 1'b0;
        m_sum    = '0;
        for (int k = 0; k < 10; k++) begin
          logic [15:0] a, a1, w;
          a  = 16'(1000 + 2 * k);
          a1 = a + 16'd1;
          w  = {mem[a1], mem[a]};
          q_idx.push_back(16'(k));
          q_data.push_back(w);
          m_sum = m_sum + w;
        end
      end
    end
  end

  // Log every word the wrap-around instance hands over.
  logic [15:0] lb_addr[$], lb_data[$], lb_idx[$];
  always @(negedge clk) begin
    if (rst && out_valid_b && out_ready_b) begin
      lb_addr.push_back(addr_b);
      lb_data.push_back(out_data_b);
      lb_idx.push_back(out_idx_b);
    end
  end

  // mode: 0 plain, 1 backpressure on word 3, 2 grant loss on word 5, 3 start mid-sweep, 4 restart from DONE
  task automatic run(input int mode, output int dur, output int first_v);
    int  ts, stall, goff;
    bit  gdone;
    stall = 0; goff = 0; gdone = 0; first_v = -1; dur = -1;
    cyc();
    start = 1'b1;
    cyc();
    ts = cnt;
    start = 1'b0;
    if (mode == 4) chk("restart_done_clear", done, 0);
    for (int i = 0; i < 200; i++) begin
      if (out_valid && first_v < 0) first_v = cnt - ts;
      if (done) begin
        dur = cnt - ts;
        break;
      end
      case (mode)
        1: begin
          if (out_valid && out_idx == 16'd3 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
            chk("bp_data", out_data, 6);
            chk("bp_idx", out_idx, 3);
          end else begin
            out_ready = 1'b1;
          end
        end
        2: begin
          if (goff > 0) begin
            bus_gnt = 1'b0;
            chk("stall_addr", addr, 1010);
            chk("stall_no_valid", out_valid, 0);
            goff--;
          end else begin
            bus_gnt = 1'b1;
          end
          if (!gdone && out_valid && out_idx == 16'd4) begin
            gdone = 1'b1;
            goff  = 4;
          end
        end
        3: start = (out_valid && out_idx == 16'd2);
        default: ;
      endcase
      cyc();
    end
    out_ready = 1'b1;
    bus_gnt   = 1'b1;
    start     = 1'b0;
    if (dur < 0) chk("sweep_timeout", 0, 1);
  endtask

  initial begin
    int dur, fv;
    rst = 1'b0; start = 1'b0; bus_gnt = 1'b1; out_ready = 1'b1;
    start_b = 1'b0; bus_gnt_b = 1'b1; out_ready_b = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int k = 0; k < 10; k++) begin
      mem[1000 + 2 * k] = 8'(9 - k);
      mem[1001 + 2 * k] = 8'h00;
    end
    mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'h12;
    mem[16'h0000] = 8'h78; mem[16'h0001] = 8'h56;

    repeat (3) cyc();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_en", en, 0);
    rst = 1'b1;
    cyc();

    run(0, dur, fv);
    chk("basic_first_valid", fv, 2);
    chk("basic_duration", dur, 21);
    chk("basic_last_data", out_data, 0);
    chk("basic_last_idx", out_idx, 9);
    chk("basic_checksum", checksum, CK_EN ? 16'h002D : 16'h0000);

    run(1, dur, fv);
    chk("bp_duration", dur, 26);

    run(2, dur, fv);
    chk("gnt_duration", dur, 25);

    run(3, dur, fv);
    chk("busy_start_duration", dur, 21);
    chk("busy_start_done", done, 1);

    run(4, dur, fv);
    chk("restart_duration", dur, 21);

    // Reset in the SEND of word 5.
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (out_valid && out_idx == 16'd5) begin
          seen = 1'b1;
          break;
        end
        cyc();
      end
      chk("reach_word5", seen, 1);
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_bus_req", bus_req, 0);
    chk("arst_addr", addr, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_idx", out_idx, 0);
    chk("arst_done", done, 0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    run(0, dur, fv);
    chk("post_rst_first_valid", fv, 2);
    chk("post_rst_duration", dur, 21);

    // Address wrap-around instance.
    cyc();
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    for (int i = 0; i < 50 && !done_b; i++) cyc();
    chk("wrap_done", done_b, 1);
    chk("wrap_count", lb_addr.size(), 2);
    if (lb_addr.size() == 2) begin
      chk("wrap_addr0", lb_addr[0], 16'hFFFE);
      chk("wrap_data0", lb_data[0], 16'h1234);
      chk("wrap_idx0", lb_idx[0], 0);
      chk("wrap_addr1", lb_addr[1], 16'h0000);
      chk("wrap_data1", lb_data[1], 16'h5678);
      chk("wrap_idx1", lb_idx[1], 1);
    end
    chk("wrap_checksum", checksum_b, CK_EN ? 16'h68AC : 16'h0000);
    chk("wrap_en", en_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_result_reader.md
# mem_result_reader

Bus initiator that sweeps a block of words out of the byte-addressed, little-endian 16-bit data memory after the CPU halts. It streams each word out over a valid/ready port to the bench logger or a debug UART. It shares the memory port with the CPU through a simple request/grant, reads with the memory's combinational read path, and never writes. It is the consumer of the result words the CPU programs store, for example at 1000..1018.

## Interface
- `BASE_ADDR`, default 1000: byte address of the first word.
- `NUM_WORDS`, default 10: number of words read per sweep. Range is 1..65535.
- `STRIDE`, default 2: byte increment between words.
- `clk`, input, 1 bit: the only clock. All state changes on its rising edge.
- `rst`, input, 1 bit: asynchronous, active-low reset (0 = reset).
- `start`, input, 1 bit: begins a sweep when sampled high in IDLE or DONE. Typically driven by PC == 16'hFFFF.
- `bus_req`, output, 1 bit: requests ownership of the memory port.
- `bus_gnt`, input, 1 bit: port granted to this block.
- `addr`, output, 16 bits: memory byte address.
- `en`, output, 1 bit: memory write enable. Held at 0 permanently (read mode).
- `rd_data`, input, 16 bits: combinational read data, `{mem[addr+1], mem[addr]}`.
- `out_data`, output, 16 bits: captured word.
- `out_idx`, output, 16 bits: index of `out_data` within the sweep, 0-based.
- `out_valid`, output, 1 bit: `out_data` and `out_idx` are valid.
- `out_ready`, input, 1 bit: the sink accepts the word.
- `busy`, output, 1 bit: high in REQ, READ and SEND.
- `done`, output, 1 bit: sticky completion flag.
- `checksum`, output, 16 bits: see Configuration.

## Operation
- States are IDLE, REQ, READ, SEND and DONE.
- **IDLE:** on `start`, clear idx and the running sum, then go to REQ.
- **REQ:**
  - `bus_req`=1.
  - When `bus_gnt`=1, go to READ.
- **READ:**
  - `bus_req`=1 and `addr` = BASE_ADDR + idx*STRIDE, computed in 16 bits and wrapping modulo 2^16.
  - If `bus_gnt`=1 at the edge: register `rd_data` into `out_data`, set `out_idx`=idx, then go to SEND.
  - If `bus_gnt`=0: no capture; stay in READ.
- **SEND:**
  - `out_valid`=1. `out_data` and `out_idx` stay stable until the handshake completes.
  - `bus_req` stays 1.
  - On `out_valid && out_ready`: if idx == NUM_WORDS-1, go to DONE; otherwise increment idx and go to READ.
- **DONE:**
  - `done`=1, `bus_req`=0.
  - On `start`, behave as in IDLE and begin a new sweep; `done` clears in the same edge.
- `start` is ignored in REQ, READ and SEND.
- `addr` = 16'h0000 whenever `bus_req`=0. While `bus_req`=1, `addr` holds the current word address.
- `en` is never asserted.

## Timing
- **Reset values:** state IDLE; `bus_req`, `out_valid`, `busy` and `done` = 0; `addr`, `out_data`, `out_idx` and `checksum` = 0.
- **Reset mid-sweep:** the block aborts immediately to the reset values. No partial word is emitted.
- **First word latency:** `start` high at edge T with `bus_gnt` tied high gives REQ in T+1, READ in T+2, and `out_valid` in T+3.
- **Throughput:** 2 cycles per word when `out_ready`=1. A full 10-word sweep reaches DONE 21 cycles after the `start` edge.
- **Backpressure:** SEND holds indefinitely while `out_ready`=0.
- **Grant loss:** losing `bus_gnt` in REQ or READ stalls the block and nothing is captured. Loss during SEND has no effect, because the data is already registered.
- **`done`:** asserts in the cycle after the last handshake and stays asserted until reset or a new `start`.

## Configuration
- Controlled by the macro `READER_CHECKSUM_EN`.
- **Defined:** a 16-bit running sum (wrapping) accumulates each word at its capture edge in READ. `checksum` presents the sum and is valid while `done`=1; it resets to 0 on a new sweep.
- **Not defined:** no accumulator is built and `checksum` is tied to 16'h0000. The port list is identical in both builds.

## Structure
- Shared package `reader_pkg`:
  - state enum (IDLE, REQ, READ, SEND, DONE);
  - word-width constant 16;
  - default BASE_ADDR, NUM_WORDS and STRIDE.
- Single module with no sub-module. The address generator and accumulator are inline registers.

## Test plan
- **Basic sweep:**
  - Stimulus: preload words 9,8,...,0 at 1000..1018; `bus_gnt`=1, `out_ready`=1; pulse `start`.
  - Response: `out_data` = 9,8,...,0 with `out_idx` 0..9 at addresses 1000,1002,...,1018; `done`=1 at start+21; `checksum` = 16'h002D with the macro, 16'h0000 without.
- **Backpressure:**
  - Stimulus: `out_ready`=0 for 5 cycles on word 3.
  - Response: `out_data`=6 and `out_idx`=3 stay stable with `out_valid` held; no word is skipped or duplicated.
- **Grant stall:**
  - Stimulus: `bus_gnt` low for 4 cycles while in READ.
  - Response: no capture and `addr` holds; the sweep resumes correctly and the total duration grows by 4 cycles.
- **Wrap-around:**
  - Stimulus: BASE_ADDR=16'hFFFE, NUM_WORDS=2.
  - Response: reads at 16'hFFFE, then 16'h0000.
- **Start while busy:**
  - Stimulus: second `start` pulse in the middle of a sweep.
  - Response: ignored. After DONE, a new `start` clears `done` and reruns from idx 0.
- **Reset mid-sweep:**
  - Stimulus: assert `rst`=0 during SEND of word 5.
  - Response: all outputs go to their reset values asynchronously; a subsequent `start` sweeps from BASE_ADDR.
